sram_frame_reader: RTL and testbench

Downstream stage of the capture path: once the pixel writer reports a finished JPEG frame, this block reads the frame back from external SRAM and streams it out a byte at a time. It handles address generation from 0 to the writer's stop address, the active-low SRAM start handshake, unpacking of each 16-bit word into two bytes (low byte first), and trimming of the byte after the FFD9 end marker. Its byte stream feeds the transmit/sending process.

---
 rtl/frame_pkg.sv | 34 +++
 rtl/sram_frame_reader_if.sv | 31 +++
 rtl/sram_read_port.sv | 68 ++++++
 rtl/sram_frame_reader.sv | 202 ++++++++++++++++++++
 tb/tb_sram_frame_reader.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_pkg.sv
// frame_pkg
// Shared types and constants for the SRAM frame readback path.
//   state_t           : main readout FSM states
//   SRAM_RW_READ      : level driven on sram_rw (this block only reads)
//   SRAM_START_ACTIVE : asserted level of the active-low sram_start strobe
//   JPEG_MARK_FF/EOI  : the two bytes of the JPEG end-of-image marker
//   is_eoi()          : end-of-image test applied to the final word of a frame

package frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_ACK,
    WAIT_DATA,
    SEND_LO,
    SEND_HI,
    DONE
  } state_t;

  localparam logic       SRAM_RW_READ      = 1'b1;
  localparam logic       SRAM_START_ACTIVE = 1'b0;
  localparam logic [7:0] JPEG_MARK_FF      = 8'hFF;
  localparam logic [7:0] JPEG_MARK_EOI     = 8'hD9;

  // True when the low byte of this word closes the frame: either the marker
  // straddles the previous word's high byte and this low byte, or the word
  // itself holds both marker bytes.
  function automatic logic is_eoi(input logic [15:0] w, input logic [7:0] prev_hi);
    return ((w[7:0] == JPEG_MARK_EOI) && (prev_hi == JPEG_MARK_FF)) ||
           (w == {JPEG_MARK_FF, JPEG_MARK_EOI});
  endfunction

endpackage

// File: rtl/sram_frame_reader_if.sv
// sram_frame_reader_if
// Bundles the SRAM read port and the outgoing byte stream of the frame reader.
//   master : the frame reader (drives address, strobe, byte stream)
//   slave  : the SRAM controller / byte consumer side
// Signals: sram_addr, sram_rw, sram_start (active low), sram_ready,
//          sram_rd_data, tx_data, tx_valid, tx_ready.

interface sram_frame_reader_if #(
  parameter int ADDR_W = 16
) ();

  logic [ADDR_W-1:0] sram_addr;
  logic              sram_rw;
  logic              sram_start;
  logic              sram_ready;
  logic [15:0]       sram_rd_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output sram_addr, sram_rw, sram_start, tx_data, tx_valid,
    input  sram_ready, sram_rd_data, tx_ready
  );

  modport slave (
    input  sram_addr, sram_rw, sram_start, tx_data, tx_valid,
    output sram_ready, sram_rd_data, tx_ready
  );

endinterface

// File: rtl/sram_read_port.sv
// sram_read_port
// Low-level single-word SRAM read helper for the frame reader.
//   clk, reset    : clock, synchronous active-high reset
//   req           : high in the cycle before the main FSM enters REQ; produces
//                   the one-cycle active-low sram_start and clears the timer
//   wait_ack      : main FSM is waiting for sram_ready to drop
//   wait_data     : main FSM is waiting for sram_ready to rise
//   sram_ready    : SRAM controller ready
//   sram_rd_data  : SRAM read data
//   sram_start    : registered active-low request strobe
//   acked         : ready dropped while waiting for the ack
//   rd_done       : ready rose while waiting for data (word latched this edge)
//   timeout       : the current wait phase has run SRAM_TIMEOUT cycles
//   word          : latched read word

module sram_read_port
  import frame_pkg::*;
#(
  parameter int SRAM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wait_ack,
  input  logic        wait_data,
  input  logic        sram_ready,
  input  logic [15:0] sram_rd_data,
  output logic        sram_start,
  output logic        acked,
  output logic        rd_done,
  output logic        timeout,
  output logic [15:0] word
);

  localparam int TW = (SRAM_TIMEOUT < 2) ? 1 : $clog2(SRAM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(SRAM_TIMEOUT);
  localparam logic [TW-1:0] TONE = TW'(1);

  logic [TW-1:0] timer;
  logic          stalled;

  assign acked   = wait_ack && !sram_ready;
  assign rd_done = wait_data && sram_ready;
  // A wait phase is stalled while its awaited ready level has not appeared.
  assign stalled = (wait_ack && sram_ready) || (wait_data && !sram_ready);
  assign timeout = stalled && (timer == TMAX);

  // The strobe is registered from the FSM's next state, so it is low exactly
  // while the FSM sits in REQ. The timer restarts for every wait phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_start <= ~SRAM_START_ACTIVE;
      timer      <= '0;
      word       <= '0;
    end else begin
      sram_start <= req ? SRAM_START_ACTIVE : ~SRAM_START_ACTIVE;
      if (req || acked) begin
        timer <= '0;
      end else if (stalled && (timer != TMAX)) begin
        timer <= timer + TONE;
      end
      if (rd_done) begin
        word <= sram_rd_data;
      end
    end
  end

endmodule

// File: rtl/sram_frame_reader.sv
// sram_frame_reader
// Reads a finished JPEG frame back from SRAM (word addresses 0..stop_addr) and
// streams it out low byte first, trimming the byte after the FFD9 marker.
//   clk, reset  : clock, synchronous active-high reset
//   frame_end   : rising edge starts a readout (ignored while busy)
//   stop_addr   : last word address of the frame, latched at the start edge
//   bus         : SRAM read port and byte stream (master side)
//   busy        : readout in progress
//   done        : one-cycle pulse after the last byte is accepted
//   error       : sticky SRAM timeout flag, cleared by the next start
//   byte_count  : bytes accepted in the current or last frame

module sram_frame_reader
  import frame_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int SRAM_TIMEOUT = 255,
  parameter int TRIM_TAIL    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_end,
  input  logic [ADDR_W-1:0] stop_addr,
  sram_frame_reader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   BC_ONE   = (ADDR_W + 1)'(1);

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W-1:0] last_q, last_n;
  logic [7:0]        prev_hi_q, prev_hi_n;
  logic [7:0]        tx_data_q, tx_data_n;
  logic              tx_valid_q, tx_valid_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              error_q, error_n;
  logic [ADDR_W:0]   bc_q, bc_n;
  logic              frame_end_q;

  logic              acked, rd_done, timeout;
  logic [15:0]       word;
  logic              sram_start;

  sram_read_port #(
    .SRAM_TIMEOUT(SRAM_TIMEOUT)
  ) u_port (
    .clk          (clk),
    .reset        (reset),
    .req          (state_n == REQ),
    .wait_ack     (state_q == WAIT_ACK),
    .wait_data    (state_q == WAIT_DATA),
    .sram_ready   (bus.sram_ready),
    .sram_rd_data (bus.sram_rd_data),
    .sram_start   (sram_start),
    .acked        (acked),
    .rd_done      (rd_done),
    .timeout      (timeout),
    .word         (word)
  );

  assign bus.sram_addr  = addr_q;
  assign bus.sram_rw    = SRAM_RW_READ;
  assign bus.sram_start = sram_start;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign byte_count     = bc_q;

  // State and output registers. frame_end is tracked every cycle so a level
  // held high, or an edge seen while busy, never starts a second readout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_q      <= '0;
      prev_hi_q   <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      bc_q        <= '0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      addr_q      <= addr_n;
      last_q      <= last_n;
      prev_hi_q   <= prev_hi_n;
      tx_data_q   <= tx_data_n;
      tx_valid_q  <= tx_valid_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      error_q     <= error_n;
      bc_q        <= bc_n;
      frame_end_q <= frame_end;
    end
  end

  // Next-state logic. Every output register is loaded from here, so outputs
  // change one edge after the condition that causes them. The last-address
  // compare precedes the increment, so an all-ones stop address never wraps.
  always_comb begin
    state_n    = state_q;
    addr_n     = addr_q;
    last_n     = last_q;
    prev_hi_n  = prev_hi_q;
    tx_data_n  = tx_data_q;
    tx_valid_n = tx_valid_q;
    busy_n     = busy_q;
    done_n     = 1'b0;
    error_n    = error_q;
    bc_n       = bc_q;

    case (state_q)
      IDLE: begin
        if (frame_end && !frame_end_q) begin
          last_n    = stop_addr;
          addr_n    = '0;
          bc_n      = '0;
          prev_hi_n = '0;
          error_n   = 1'b0;
          busy_n    = 1'b1;
          state_n   = REQ;
        end
      end

      REQ: begin
        state_n = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (acked) begin
          state_n = WAIT_DATA;
        end else if (timeout) begin
          error_n = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end

      WAIT_DATA: begin
        if (rd_done) begin
          tx_data_n  = bus.sram_rd_data[7:0];
          tx_valid_n = 1'b1;
          state_n    = SEND_LO;
        end else if (timeout) begin
          error_n = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end

      SEND_LO: begin
        if (bus.tx_ready) begin
          bc_n = bc_q + BC_ONE;
          if ((addr_q == last_q) && (TRIM_TAIL != 0) && is_eoi(word, prev_hi_q)) begin
            tx_valid_n = 1'b0;
            done_n     = 1'b1;
            busy_n     = 1'b0;
            state_n    = DONE;
          end else begin
            tx_data_n = word[15:8];
            state_n   = SEND_HI;
          end
        end
      end

      SEND_HI: begin
        if (bus.tx_ready) begin
          bc_n       = bc_q + BC_ONE;
          prev_hi_n  = word[15:8];
          tx_valid_n = 1'b0;
          if (addr_q == last_q) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = DONE;
          end else begin
            addr_n  = addr_q + ADDR_ONE;
            state_n = REQ;
          end
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_frame_reader.sv
// tb_sram_frame_reader
// Directed bench for sram_frame_reader with a small SRAM controller model,
// a byte-stream monitor and one task per scenario.

module tb_sram_frame_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_end;
  logic [15:0] stop_addr;
  logic        busy, done, error;
  logic [16:0] byte_count;

  int total = 0;
  int bad   = 0;

  sram_frame_reader_if #(.ADDR_W(16)) bus ();

  sram_frame_reader #(
    .ADDR_W(16), .SRAM_TIMEOUT(255), .TRIM_TAIL(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_end  (frame_end),
    .stop_addr  (stop_addr),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // SRAM controller model: on a low start strobe it drops ready, then after
  // three more edges raises ready with the addressed word. Stuck mode keeps
  // ready high forever.
  logic [15:0] mem [16];
  logic        sram_stuck = 1'b0;
  int          model_cnt  = 0;
  logic [3:0]  model_addr;

  always @(posedge clk) begin
    if (reset || sram_stuck) begin
      bus.sram_ready <= 1'b1;
      model_cnt      <= 0;
      if (reset) bus.sram_rd_data <= 16'h0000;
    end else if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) begin
        bus.sram_ready   <= 1'b1;
        bus.sram_rd_data <= mem[model_addr];
      end
    end else if (bus.sram_start == 1'b0) begin
      bus.sram_ready <= 1'b0;
      model_cnt      <= 3;
      model_addr     <= bus.sram_addr[3:0];
    end
  end

  // Consumer: always ready, or ready two cycles out of three under backpressure.
  logic bp_mode = 1'b0;
  int   cyc     = 0;
  always @(posedge clk) begin
    #1;
    bus.tx_ready = bp_mode ? ((cyc % 3) != 2) : 1'b1;
    cyc++;
  end

  // Monitor on the falling edge: collects accepted bytes, done pulses, start
  // strobes, and any change of a byte that is stalled by backpressure.
  logic [7:0] got [$];
  int   done_cnt    = 0;
  int   start_cnt   = 0;
  int   stable_viol = 0;
  logic hold_pend   = 1'b0;
  logic [7:0] hold_data;

  always @(negedge clk) begin
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) got.push_back(bus.tx_data);
    if (done === 1'b1) done_cnt++;
    if (bus.sram_start === 1'b0) start_cnt++;
    if (hold_pend && !(bus.tx_valid === 1'b1 && bus.tx_data === hold_data)) stable_viol++;
    hold_pend = (reset !== 1'b1) && (bus.tx_valid === 1'b1) && (bus.tx_ready === 1'b0);
    hold_data = bus.tx_data;
  end

  function automatic logic [63:0] packed_got();
    logic [63:0] v = '0;
    foreach (got[i]) v = {v[55:0], got[i]};
    return v;
  endfunction

  task automatic clear_mon();
    got.delete();
    done_cnt    = 0;
    start_cnt   = 0;
    stable_viol = 0;
  endtask

  task automatic start_edge();
    @(posedge clk); #1 frame_end = 1'b1;
    @(posedge clk); #1 frame_end = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit expired);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    expired = (done_cnt == 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic load_basic();
    mem[0] = 16'h1122; mem[1] = 16'h3344; mem[2] = 16'hD9FF;
    stop_addr = 16'd2;
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_end = 1'b0; stop_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.tx_valid, busy, done, error} !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_flags: got %b expected 0000", {bus.tx_valid, busy, done, error});
    end
    total++;
    if ({bus.sram_start, bus.sram_rw} !== 2'b11) begin
      bad++; $display("[TB] FAIL reset_start_rw: got %b expected 11", {bus.sram_start, bus.sram_rw});
    end
    total++;
    if (bus.sram_addr !== 16'h0) begin
      bad++; $display("[TB] FAIL reset_addr: got %0h expected 0", bus.sram_addr);
    end
    total++;
    if (byte_count !== 17'h0 || bus.tx_data !== 8'h00) begin
      bad++; $display("[TB] FAIL reset_count_data: got %0h/%0h expected 0/0", byte_count, bus.tx_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int  first_valid = -1;
    logic start_at1 = 1'b1, start_at2 = 1'b0;
    bit  exp;
    load_basic();
    clear_mon();
    @(posedge clk); #1 frame_end = 1'b1;
    for (int i = 0; i < 40 && first_valid < 0; i++) begin
      @(negedge clk);
      if (i == 1) begin start_at1 = bus.sram_start; frame_end = 1'b0; end
      if (i == 2) start_at2 = bus.sram_start;
      if (bus.tx_valid === 1'b1) first_valid = i;
    end
    total++;
    if (start_at1 !== 1'b0 || start_at2 !== 1'b1) begin
      bad++; $display("[TB] FAIL basic_start_strobe: got %b%b expected 01", start_at1, start_at2);
    end
    total++;
    if (first_valid != 6) begin
      bad++; $display("[TB] FAIL basic_first_valid: got cycle %0d expected 6", first_valid);
    end
    wait_done(300, exp);
    total++;
    if (exp) begin
      bad++; $display("[TB] FAIL basic_done_timeout: got no done expected done");
    end
    total++;
    if (packed_got() !== 64'h0000_2211_4433_FFD9 || got.size() != 6) begin
      bad++; $display("[TB] FAIL basic_bytes: got %0h (%0d) expected 22114433ffd9 (6)", packed_got(), got.size());
    end
    total++;
    if (byte_count !== 17'd6 || done_cnt != 1 || start_cnt != 3) begin
      bad++; $display("[TB] FAIL basic_counts: got bc=%0d done=%0d start=%0d expected 6/1/3", byte_count, done_cnt, start_cnt);
    end
    total++;
    if (busy !== 1'b0 || bus.sram_addr !== 16'd2 || bus.tx_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL basic_end_state: got busy=%b addr=%0h valid=%b expected 0/2/0", busy, bus.sram_addr, bus.tx_valid);
    end
  endtask

  task automatic test_trim();
    bit exp;
    mem[0] = 16'hFF00; mem[1] = 16'h55D9; stop_addr = 16'd1;
    clear_mon();
    start_edge();
    wait_done(300, exp);
    total++;
    if (exp || packed_got() !== 64'h0000_0000_0000_FFD9 || got.size() != 3) begin
      bad++; $display("[TB] FAIL trim_bytes: got %0h (%0d) expected 00ffd9 (3)", packed_got(), got.size());
    end
    total++;
    if (byte_count !== 17'd3 || done_cnt != 1) begin
      bad++; $display("[TB] FAIL trim_count: got bc=%0d done=%0d expected 3/1", byte_count, done_cnt);
    end
  endtask

  task automatic test_single_word();
    bit exp;
    mem[0] = 16'hABCD; stop_addr = 16'd0;
    clear_mon();
    start_edge();
    wait_done(200, exp);
    total++;
    if (exp || packed_got() !== 64'h0000_0000_0000_CDAB || got.size() != 2 || start_cnt != 1) begin
      bad++; $display("[TB] FAIL single_word: got %0h (%0d) start=%0d expected cdab (2) start=1", packed_got(), got.size(), start_cnt);
    end
    mem[0] = 16'hFFD9;
    clear_mon();
    start_edge();
    wait_done(200, exp);
    total++;
    if (exp || packed_got() !== 64'h0000_0000_0000_00D9 || got.size() != 1 || byte_count !== 17'd1) begin
      bad++; $display("[TB] FAIL single_eoi_word: got %0h (%0d) bc=%0d expected d9 (1) bc=1", packed_got(), got.size(), byte_count);
    end
  endtask

  task automatic test_backpressure();
    bit exp;
    load_basic();
    bp_mode = 1'b1;
    clear_mon();
    start_edge();
    wait_done(400, exp);
    bp_mode = 1'b0;
    total++;
    if (exp || packed_got() !== 64'h0000_2211_4433_FFD9 || got.size() != 6) begin
      bad++; $display("[TB] FAIL bp_bytes: got %0h (%0d) expected 22114433ffd9 (6)", packed_got(), got.size());
    end
    total++;
    if (stable_viol != 0 || byte_count !== 17'd6 || done_cnt != 1) begin
      bad++; $display("[TB] FAIL bp_stability: got viol=%0d bc=%0d done=%0d expected 0/6/1", stable_viol, byte_count, done_cnt);
    end
  endtask

  task automatic test_level_hold();
    bit exp;
    load_basic();
    clear_mon();
    @(posedge clk); #1 frame_end = 1'b1;
    repeat (8) @(posedge clk);
    #1 frame_end = 1'b0;
    @(posedge clk); #1 frame_end = 1'b1;
    wait_done(300, exp);
    repeat (10) @(negedge clk);
    total++;
    if (exp || start_cnt != 3 || done_cnt != 1) begin
      bad++; $display("[TB] FAIL level_single_readout: got start=%0d done=%0d expected 3/1", start_cnt, done_cnt);
    end
    total++;
    if (got.size() != 6 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL level_no_retrigger: got bytes=%0d busy=%b expected 6/0", got.size(), busy);
    end
    frame_end = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n_busy = 0;
    bit exp;
    load_basic();
    sram_stuck = 1'b1;
    clear_mon();
    start_edge();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n_busy++;
      else break;
    end
    total++;
    if (busy !== 1'b0 || error !== 1'b1 || done_cnt != 0) begin
      bad++; $display("[TB] FAIL timeout_abort: got busy=%b error=%b done=%0d expected 0/1/0", busy, error, done_cnt);
    end
    total++;
    if (n_busy < 255 || n_busy > 259) begin
      bad++; $display("[TB] FAIL timeout_length: got %0d busy cycles expected 255..259", n_busy);
    end
    sram_stuck = 1'b0;
    repeat (3) @(negedge clk);
    clear_mon();
    start_edge();
    @(negedge clk);
    total++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL timeout_restart: got error=%b busy=%b expected 0/1", error, busy);
    end
    wait_done(300, exp);
    total++;
    if (exp || packed_got() !== 64'h0000_2211_4433_FFD9 || error !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout_recovery: got %0h error=%b expected 22114433ffd9/0", packed_got(), error);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    bit exp;
    mem[0] = 16'h0102; mem[1] = 16'h0304; mem[2] = 16'h0506; mem[3] = 16'h0708;
    stop_addr = 16'd3;
    clear_mon();
    start_edge();
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.tx_valid === 1'b1 && bus.sram_addr === 16'd3 && byte_count === 17'd7) found = 1;
    end
    total++;
    if (!found || bus.tx_data !== 8'h07) begin
      bad++; $display("[TB] FAIL midreset_reach_hi: got found=%0d data=%0h expected 1/07", found, bus.tx_data);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.tx_valid, busy, done, error} !== 4'b0000 || bus.sram_start !== 1'b1) begin
      bad++; $display("[TB] FAIL midreset_flags: got %b start=%b expected 0000/1", {bus.tx_valid, busy, done, error}, bus.sram_start);
    end
    total++;
    if (bus.sram_addr !== 16'h0 || byte_count !== 17'h0 || bus.tx_data !== 8'h00) begin
      bad++; $display("[TB] FAIL midreset_regs: got addr=%0h bc=%0h data=%0h expected 0/0/0", bus.sram_addr, byte_count, bus.tx_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_mon();
    start_edge();
    wait_done(300, exp);
    total++;
    if (exp || packed_got() !== 64'h0201_0403_0605_0807 || byte_count !== 17'd8) begin
      bad++; $display("[TB] FAIL midreset_refetch: got %0h bc=%0d expected 0201040306050807/8", packed_got(), byte_count);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_trim();
    test_single_word();
    test_backpressure();
    test_level_hold();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
